// File: rtl/ntru_pkg.sv
// ntru_pkg: shared NTRU packer types and helpers.
//   coeff_w(poly_q) : coefficient bit width (11/12/13) for a modulus code
//   Q_2048/Q_4096/Q_8192 : modulus codes
//   state_t         : packer FSM states
package ntru_pkg;
  localparam logic [1:0] Q_2048 = 2'b00;
  localparam logic [1:0] Q_4096 = 2'b01;
  localparam logic [1:0] Q_8192 = 2'b11;
  typedef enum logic {RUN, FLUSH} state_t;
  function automatic logic [3:0] coeff_w(input logic [1:0] poly_q);
    return poly_q == Q_2048 ? 4'd11 : poly_q == Q_4096 ? 4'd12 : 4'd13;
  endfunction
endpackage

// File: rtl/ntru_pack_acc.sv
// ntru_pack_acc: little-endian bit accumulator with fill counter.
//   clk, resetn : clock, synchronous active-low reset
//   push, coeff, w : append coeff[w-1:0] above the current fill
//   pop, word   : word = lowest 32 bits; pop shifts them out
//   fill        : number of valid bits held
// push and pop are never asserted together by the owner.
module ntru_pack_acc #(
  parameter int ACC_W = 64,
  parameter int F_W = 7
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic             pop,
  input  logic [31:0]      coeff,
  input  logic [3:0]       w,
  output logic [31:0]      word,
  output logic [F_W-1:0]   fill
);
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] mask;
  assign mask = (ACC_W'(1) << w) - ACC_W'(1);
  assign word = acc[31:0];
  always_ff @(posedge clk) begin
    if (!resetn) begin
      acc <= '0;
      fill <= '0;
    end else if (push) begin
      acc <= acc | ((ACC_W'(coeff) & mask) << fill);
      fill <= fill + F_W'(w);
    end else if (pop) begin
      acc <= acc >> 32;
      fill <= fill > F_W'(32) ? fill - F_W'(32) : '0;
    end
  end
endmodule

// File: rtl/ntru_coeff_packer.sv
// ntru_coeff_packer: packs 11/12/13-bit coefficients into a 32-bit AXI-Stream.
//   clk, resetn        : clock, synchronous active-low reset
//   poly_n, poly_q     : coefficient count and modulus code, latched on first beat
//   s_tdata/s_tvalid/s_tready/s_tlast : one coefficient per input beat
//   m_tdata/m_tvalid/m_tready/m_tlast : packed words, tlast on final word
//   frame_err          : sticky, s_tlast seen on the wrong beat
//   drop_last          : only with NTRU_PACK_DROP_LAST_EN; skip packing the n-th coefficient
module ntru_coeff_packer
  import ntru_pkg::*;
#(
  parameter int N_W = 10,
  parameter int ACC_W = 64
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic [N_W-1:0] poly_n,
  input  logic [1:0]     poly_q,
`ifdef NTRU_PACK_DROP_LAST_EN
  input  logic           drop_last,
`endif
  input  logic [31:0]    s_tdata,
  input  logic           s_tvalid,
  output logic           s_tready,
  input  logic           s_tlast,
  output logic [31:0]    m_tdata,
  output logic           m_tvalid,
  input  logic           m_tready,
  output logic           m_tlast,
  output logic           frame_err
);
  localparam int F_W = $clog2(ACC_W + 1);
  state_t state, state_nx;
  logic [N_W-1:0] in_cnt, n_r, n_cur;
  logic [3:0] w_r, w_cur;
  logic drop_in, drop_r, drop_cur;
  logic first, accept, last_beat, push, pop, done;
  logic [F_W-1:0] fill;
  logic [31:0] word;
`ifdef NTRU_PACK_DROP_LAST_EN
  assign drop_in = drop_last;
`else
  assign drop_in = 1'b0;
`endif
  // the first beat of a polynomial uses the live config, later beats the latched copy
  assign first = in_cnt == '0;
  assign n_cur = first ? poly_n : n_r;
  assign w_cur = first ? coeff_w(poly_q) : w_r;
  assign drop_cur = first ? drop_in : drop_r;
  assign s_tready = resetn && state == RUN && fill < F_W'(32);
  assign accept = s_tvalid && s_tready;
  assign last_beat = {1'b0, in_cnt} + (N_W + 1)'(1) == {1'b0, n_cur};
  assign push = accept && !(last_beat && drop_cur);
  assign pop = (fill >= F_W'(32) || (state == FLUSH && fill != '0)) && (!m_tvalid || m_tready);
  // leave FLUSH when the tlast word is taken, or when nothing is left to send
  assign done = m_tvalid ? m_tready && m_tlast : fill == '0;
  always_comb begin
    state_nx = state == RUN ? (accept && last_beat ? FLUSH : RUN) : (done ? RUN : FLUSH);
  end
  ntru_pack_acc #(.ACC_W(ACC_W), .F_W(F_W)) u_acc (
    .clk(clk),
    .resetn(resetn),
    .push(push),
    .pop(pop),
    .coeff(s_tdata),
    .w(w_cur),
    .word(word),
    .fill(fill)
  );
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= RUN;
      in_cnt <= '0;
      n_r <= '0;
      w_r <= '0;
      drop_r <= 1'b0;
      m_tdata <= '0;
      m_tvalid <= 1'b0;
      m_tlast <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state <= state_nx;
      in_cnt <= state == FLUSH && done ? '0 : accept ? in_cnt + 1'b1 : in_cnt;
      if (accept && first) begin
        n_r <= poly_n;
        w_r <= coeff_w(poly_q);
        drop_r <= drop_in;
      end
      if (accept && s_tlast != last_beat) frame_err <= 1'b1;
      if (pop) begin
        m_tdata <= word;
        m_tvalid <= 1'b1;
        m_tlast <= state == FLUSH && fill <= F_W'(32);
      end else if (m_tready) begin
        m_tvalid <= 1'b0;
        m_tlast <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ntru_coeff_packer.sv
// tb_ntru_coeff_packer: scoreboard bench for ntru_coeff_packer against a bit-queue packing model.
module tb_ntru_coeff_packer;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [9:0] poly_n = '0;
  logic [1:0] poly_q = '0;
  logic drop_last = 1'b0;
  logic [31:0] s_tdata = '0;
  logic s_tvalid = 1'b0;
  logic s_tlast = 1'b0;
  logic m_tready = 1'b1;
  logic s_tready, m_tvalid, m_tlast, frame_err;
  logic [31:0] m_tdata;
  always #5 clk = ~clk;
  ntru_coeff_packer dut (
    .clk(clk),
    .resetn(resetn),
    .poly_n(poly_n),
    .poly_q(poly_q),
`ifdef NTRU_PACK_DROP_LAST_EN
    .drop_last(drop_last),
`endif
    .s_tdata(s_tdata),
    .s_tvalid(s_tvalid),
    .s_tready(s_tready),
    .s_tlast(s_tlast),
    .m_tdata(m_tdata),
    .m_tvalid(m_tvalid),
    .m_tready(m_tready),
    .m_tlast(m_tlast),
    .frame_err(frame_err)
  );
  typedef struct {
    logic [31:0] d;
    logic l;
  } exp_t;
  exp_t sbq[$];
  int checks = 0;
  int passes = 0;
  bit bp_en = 1'b0;
  int wcnt = 0;
  int last_cnt = 0;
  logic [31:0] first_w = '0;
  logic [31:0] last_w = '0;
  bit stall_v = 1'b0;
  logic [32:0] stall_d = '0;
  task automatic finish_run;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  endtask
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  initial begin
    #900000;
    checks++;
    $display("FAIL watchdog: simulation time limit reached");
    finish_run();
  end
  initial begin
    int k = 0;
    forever begin
      @(posedge clk);
      #1;
      m_tready = bp_en ? (k % 3 != 2) : 1'b1;
      k++;
    end
  end
  always @(negedge clk) begin
    if (resetn) begin
      if (stall_v) chk("stall hold", {m_tvalid, m_tlast, m_tdata}, {1'b1, stall_d});
      stall_v = m_tvalid && !m_tready;
      stall_d = {m_tlast, m_tdata};
      if (m_tvalid && m_tready) begin
        if (sbq.size() == 0) chk("unexpected word", {m_tlast, m_tdata}, 64'hDEAD);
        else begin
          exp_t e;
          e = sbq.pop_front();
          chk("word data", m_tdata, e.d);
          chk("word tlast", m_tlast, e.l);
        end
        wcnt++;
        if (wcnt == 1) first_w = m_tdata;
        if (m_tlast) begin
          last_cnt = wcnt;
          last_w = m_tdata;
          wcnt = 0;
        end
      end
    end else begin
      stall_v = 1'b0;
      wcnt = 0;
    end
  end
  task automatic push_expect(input logic [31:0] c[$], input int w, input int neff);
    bit bs[$];
    int nw;
    for (int i = 0; i < neff; i++)
      for (int b = 0; b < w; b++) bs.push_back(c[i][b]);
    while (bs.size() % 32 != 0) bs.push_back(1'b0);
    nw = bs.size() / 32;
    for (int k = 0; k < nw; k++) begin
      exp_t e;
      for (int b = 0; b < 32; b++) e.d[b] = bs[32 * k + b];
      e.l = k == nw - 1;
      sbq.push_back(e);
    end
  endtask
  task automatic check_reset_outputs;
    chk("reset m_tvalid", m_tvalid, 0);
    chk("reset m_tlast", m_tlast, 0);
    chk("reset m_tdata", m_tdata, 0);
    chk("reset frame_err", frame_err, 0);
    chk("reset s_tready", s_tready, 0);
  endtask
  task automatic do_reset;
    resetn = 1'b0;
    s_tvalid = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1;
    sbq.delete();
    resetn = 1'b1;
  endtask
  task automatic send_poly(input int n, input int q, input bit drop, input int mode, input int bad_at, input bit gap, input int abort_at);
    logic [31:0] c[$];
    int w;
    int tick = 0;
    int t = 0;
    w = q == 0 ? 11 : q == 1 ? 12 : 13;
    for (int i = 0; i < n; i++)
      c.push_back(mode == 0 ? (i & 32'hFFF) : mode == 1 ? 32'hFFFFFFFF : mode == 2 ? 32'hFFFFF800 : $urandom);
    push_expect(c, w, drop ? n - 1 : n);
    poly_n = n[9:0];
    poly_q = q[1:0];
    drop_last = drop;
    for (int i = 0; i < n; i++) begin
      bit got = 1'b0;
      int guard = 0;
      s_tdata = c[i];
      s_tlast = (i == n - 1) != (i == bad_at);
      while (!got) begin
        s_tvalid = !(gap && tick % 4 == 3);
        tick++;
        @(negedge clk);
        got = s_tvalid && s_tready;
        @(posedge clk);
        #1;
        if (++guard > 200) begin
          chk("accept timeout", 0, 1);
          finish_run();
        end
      end
      if (i == bad_at) chk("frame_err set", frame_err, 1);
      if (i + 1 == abort_at) begin
        do_reset();
        return;
      end
    end
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    while (sbq.size() != 0 && t < 5000) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain", sbq.size(), 0);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    send_poly(821, 1, 1'b0, 0, -1, 1'b0, 0);
    chk("t1 count", last_cnt, 308);
    chk("t1 word0", first_w, 32'h02001000);
    chk("t1 last pad", last_w[31:28], 0);
    send_poly(509, 0, 1'b0, 1, -1, 1'b0, 0);
    chk("t2 count", last_cnt, 175);
    chk("t2 last word", last_w, 32'h7FFFFFFF);
    send_poly(300, 0, 1'b0, 2, -1, 1'b0, 0);
    chk("t3 frame_err", frame_err, 0);
    bp_en = 1'b1;
    send_poly(821, 1, 1'b0, 0, -1, 1'b1, 0);
    chk("t4 count", last_cnt, 308);
    chk("t4 word0", first_w, 32'h02001000);
    bp_en = 1'b0;
    send_poly(821, 1, 1'b0, 0, 100, 1'b0, 0);
    chk("t5 frame_err sticky", frame_err, 1);
    chk("t5 count", last_cnt, 308);
    send_poly(821, 1, 1'b0, 0, -1, 1'b0, 200);
    send_poly(821, 1, 1'b0, 0, -1, 1'b0, 0);
    chk("t5 post-reset count", last_cnt, 308);
    chk("t5 post-reset word0", first_w, 32'h02001000);
    chk("t5 post-reset frame_err", frame_err, 0);
`ifdef NTRU_PACK_DROP_LAST_EN
    send_poly(701, 3, 1'b1, 1, -1, 1'b0, 0);
    chk("t6 drop count", last_cnt, 285);
    chk("t6 drop last word", last_w, 32'h00000FFF);
`endif
    send_poly(701, 3, 1'b0, 1, -1, 1'b0, 0);
    chk("t6 count", last_cnt, 285);
    chk("t6 last word", last_w, 32'h01FFFFFF);
    for (int r = 0; r < 8; r++) begin
      bp_en = $urandom_range(0, 1) == 1;
      send_poly($urandom_range(2, 120), $urandom_range(0, 3), 1'b0, 3, -1, $urandom_range(0, 1) == 1, 0);
    end
    bp_en = 1'b0;
    chk("random frame_err", frame_err, 0);
    finish_run();
  end
endmodule
